ps2_key_ctrl: RTL and testbench

Sequencer between the ps2_keyboard receive FIFO and downstream consumers: the seven-segment display, the VGA character renderer and the LEDs.
- Pops scan-code bytes from the FIFO with a one-cycle nextdata_n strobe.
- Parses E0 (extended) and F0 (break) prefixes and tracks the held key.
- Counts distinct key presses.
- Presents one decoded key event at a time on a valid/ready handshake, back-pressuring the FIFO while an event is pending.

---
 rtl/ps2_key_ctrl.sv | 151 +++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl
//   Sequencer between the ps2_keyboard receive FIFO and downstream consumers
//   (seven-segment display, VGA character renderer, LEDs). Pops scan-code
//   bytes with a one-cycle active-low strobe, parses E0/F0 prefixes, tracks
//   the held key, counts distinct presses and presents one decoded event at a
//   time on a valid/ready handshake.
//
// Parameters
//   CNT_W          width of press counter (wraps)
//   FILTER_REPEAT  1: typematic repeat makes are dropped; 0: emitted with evt_rpt=1
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   kb_data/kb_ready       FIFO head byte / FIFO non-empty
//   kb_overflow            FIFO overflow flag (sets sticky err)
//   kb_nextdata_n          pop strobe, active low, one cycle per byte
//   evt_valid/evt_ready    event handshake
//   evt_code/ext/brk/rpt   decoded event fields
//   key_down, held_code    held-key state, held_code = {ext, code}
//   press_cnt              number of distinct presses
//   err, clr_err           sticky overflow error and its clear
module ps2_key_ctrl #(
   parameter int unsigned CNT_W         = 8,
   parameter bit          FILTER_REPEAT = 1'b1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [7:0]       kb_data,
   input  logic             kb_ready,
   input  logic             kb_overflow,
   output logic             kb_nextdata_n,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [7:0]       evt_code,
   output logic             evt_ext,
   output logic             evt_brk,
   output logic             evt_rpt,
   output logic             key_down,
   output logic [8:0]       held_code,
   output logic [CNT_W-1:0] press_cnt,
   output logic             err,
   input  logic             clr_err
);

   typedef enum logic {IDLE, POP} state_t;

   state_t     state_q, state_d;
   logic [7:0] byte_q;
   logic       ext_q, brk_q;

   logic       pop_go;
   logic       is_e0, is_f0;
   logic       hit;
   logic       decode;
   logic       emit;
   logic       new_press;

   // Next state and decode. A pop is only started when the event register
   // is free or being drained this edge, so a POP cycle never finds
   // evt_valid set and the new event can always be loaded.
   always_comb begin
      state_d   = state_q;
      pop_go    = 1'b0;
      is_e0     = (byte_q == 8'hE0);
      is_f0     = (byte_q == 8'hF0);
      hit       = key_down && (held_code == {ext_q, byte_q});
      decode    = 1'b0;
      emit      = 1'b0;
      new_press = 1'b0;
      case (state_q)
         IDLE: begin
            if (kb_ready && (!evt_valid || evt_ready)) begin
               pop_go  = 1'b1;
               state_d = POP;
            end
         end
         POP: begin
            state_d   = IDLE;
            decode    = !is_e0 && !is_f0;
            emit      = decode && (brk_q || !hit || !FILTER_REPEAT);
            new_press = decode && !brk_q && !hit;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         kb_nextdata_n <= 1'b1;
         byte_q        <= '0;
         ext_q         <= 1'b0;
         brk_q         <= 1'b0;
         evt_valid     <= 1'b0;
         evt_code      <= '0;
         evt_ext       <= 1'b0;
         evt_brk       <= 1'b0;
         evt_rpt       <= 1'b0;
         key_down      <= 1'b0;
         held_code     <= '0;
         press_cnt     <= '0;
         err           <= 1'b0;
      end else begin
         kb_nextdata_n <= !pop_go;
         if (pop_go) byte_q <= kb_data;

         // Overflow corrupts any partial prefix sequence.
         if (kb_overflow) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
         end else if (state_q == POP) begin
            if (is_e0) begin
               ext_q <= 1'b1;
            end else if (is_f0) begin
               brk_q <= 1'b1;
            end else begin
               ext_q <= 1'b0;
               brk_q <= 1'b0;
            end
         end

         if (decode) begin
            if (brk_q) begin
               if (hit) key_down <= 1'b0;
            end else if (new_press) begin
               key_down  <= 1'b1;
               held_code <= {ext_q, byte_q};
               press_cnt <= press_cnt + CNT_W'(1);
            end
         end

         if (emit) begin
            evt_valid <= 1'b1;
            evt_code  <= byte_q;
            evt_ext   <= ext_q;
            evt_brk   <= brk_q;
            evt_rpt   <= !brk_q && hit;
         end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
         end

         if (kb_overflow)  err <= 1'b1;
         else if (clr_err) err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl. Two instances share stimulus: dut filters
// typematic repeats, dut_nf reports them. A small FIFO model feeds kb_data.
module tb_ps2_key_ctrl;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] kb_data = 8'h00;
   logic       kb_ready = 1'b0;
   logic       kb_overflow = 1'b0;
   logic       evt_ready = 1'b1;
   logic       clr_err = 1'b0;

   logic       nd_n, evt_valid, evt_ext, evt_brk, evt_rpt, key_down, err;
   logic [7:0] evt_code, press_cnt;
   logic [8:0] held_code;

   logic       nf_nd_n, nf_evt_valid, nf_evt_ext, nf_evt_brk, nf_evt_rpt, nf_key_down, nf_err;
   logic [7:0] nf_evt_code, nf_press_cnt;
   logic [8:0] nf_held_code;

   ps2_key_ctrl #(.CNT_W(8), .FILTER_REPEAT(1'b1)) dut (
      .clk(clk), .resetn(resetn), .kb_data(kb_data), .kb_ready(kb_ready),
      .kb_overflow(kb_overflow), .kb_nextdata_n(nd_n), .evt_valid(evt_valid),
      .evt_ready(evt_ready), .evt_code(evt_code), .evt_ext(evt_ext),
      .evt_brk(evt_brk), .evt_rpt(evt_rpt), .key_down(key_down),
      .held_code(held_code), .press_cnt(press_cnt), .err(err), .clr_err(clr_err)
   );

   ps2_key_ctrl #(.CNT_W(8), .FILTER_REPEAT(1'b0)) dut_nf (
      .clk(clk), .resetn(resetn), .kb_data(kb_data), .kb_ready(kb_ready),
      .kb_overflow(kb_overflow), .kb_nextdata_n(nf_nd_n), .evt_valid(nf_evt_valid),
      .evt_ready(evt_ready), .evt_code(nf_evt_code), .evt_ext(nf_evt_ext),
      .evt_brk(nf_evt_brk), .evt_rpt(nf_evt_rpt), .key_down(nf_key_down),
      .held_code(nf_held_code), .press_cnt(nf_press_cnt), .err(nf_err), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // FIFO model: head visible on kb_data, popped when the strobe is low.
   logic [7:0] fifo[$];
   int         strobe_cnt = 0;
   logic       prev_low = 1'b0;
   always @(negedge clk) begin
      if (!nd_n) begin
         strobe_cnt++;
         if (fifo.size() != 0) void'(fifo.pop_front());
      end
      if (!nd_n && prev_low) begin
         errors++;
         $display("FAIL strobe_double: strobe low two cycles at %0t", $time);
      end
      prev_low = !nd_n;
      kb_ready = (fifo.size() != 0);
      kb_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
   end

   // Event monitors, packed as {ext, brk, rpt, code}.
   logic [10:0] ev_q[$];
   logic [10:0] nf_ev_q[$];
   always @(negedge clk) begin
      if (evt_valid && evt_ready)    ev_q.push_back({evt_ext, evt_brk, evt_rpt, evt_code});
      if (nf_evt_valid && evt_ready) nf_ev_q.push_back({nf_evt_ext, nf_evt_brk, nf_evt_rpt, nf_evt_code});
   end

   task automatic feed(input logic [7:0] b);
      fifo.push_back(b);
      repeat (4) @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [7:0]  b;
      bit          ev;     // filtering instance emits
      bit          nf_ev;  // non-filtering instance emits
      logic [10:0] evt;    // {ext,brk,rpt,code} as seen by dut_nf
      logic        kd;
      logic [8:0]  held;
      logic [7:0]  cnt;
   } vec_t;

   vec_t tbl[15];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, nn;

      tbl[0]  = '{8'h15, 1'b0, 1'b1, {3'b001, 8'h15}, 1'b1, 9'h015, 8'd1};
      tbl[1]  = '{8'hF0, 1'b0, 1'b0, 11'h000,         1'b1, 9'h015, 8'd1};
      tbl[2]  = '{8'h15, 1'b1, 1'b1, {3'b010, 8'h15}, 1'b0, 9'h015, 8'd1};
      tbl[3]  = '{8'hE0, 1'b0, 1'b0, 11'h000,         1'b0, 9'h015, 8'd1};
      tbl[4]  = '{8'h75, 1'b1, 1'b1, {3'b100, 8'h75}, 1'b1, 9'h175, 8'd2};
      tbl[5]  = '{8'hE0, 1'b0, 1'b0, 11'h000,         1'b1, 9'h175, 8'd2};
      tbl[6]  = '{8'hF0, 1'b0, 1'b0, 11'h000,         1'b1, 9'h175, 8'd2};
      tbl[7]  = '{8'h75, 1'b1, 1'b1, {3'b110, 8'h75}, 1'b0, 9'h175, 8'd2};
      tbl[8]  = '{8'h1C, 1'b1, 1'b1, {3'b000, 8'h1C}, 1'b1, 9'h01C, 8'd3};
      tbl[9]  = '{8'h32, 1'b1, 1'b1, {3'b000, 8'h32}, 1'b1, 9'h032, 8'd4};
      tbl[10] = '{8'hF0, 1'b0, 1'b0, 11'h000,         1'b1, 9'h032, 8'd4};
      tbl[11] = '{8'h1C, 1'b1, 1'b1, {3'b010, 8'h1C}, 1'b1, 9'h032, 8'd4};
      tbl[12] = '{8'h32, 1'b0, 1'b1, {3'b001, 8'h32}, 1'b1, 9'h032, 8'd4};
      tbl[13] = '{8'hE0, 1'b0, 1'b0, 11'h000,         1'b1, 9'h032, 8'd4};
      tbl[14] = '{8'h32, 1'b1, 1'b1, {3'b100, 8'h32}, 1'b1, 9'h132, 8'd5};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_strobe", nd_n, 1'b1);
      check("rst_valid", evt_valid, 1'b0);
      check("rst_code", evt_code, 8'h00);
      check("rst_flags", {evt_ext, evt_brk, evt_rpt}, 3'b000);
      check("rst_key", {key_down, held_code}, 10'h000);
      check("rst_cnt", press_cnt, 8'd0);
      check("rst_err", err, 1'b0);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // First byte: strobe one cycle later, event two cycles later
      fifo.push_back(8'h15);
      @(posedge clk);
      #1;
      check("first_strobe", nd_n, 1'b0);
      check("first_valid_early", evt_valid, 1'b0);
      @(posedge clk);
      #1;
      check("first_strobe_hi", nd_n, 1'b1);
      check("first_valid", evt_valid, 1'b1);
      check("first_evt", {evt_ext, evt_brk, evt_rpt, evt_code}, {3'b000, 8'h15});
      check("first_key", {key_down, held_code}, {1'b1, 9'h015});
      check("first_cnt", press_cnt, 8'd1);
      repeat (2) @(posedge clk);
      #1;

      // Table of single bytes with evt_ready held high
      for (int i = 0; i < 15; i++) begin
         n  = ev_q.size();
         nn = nf_ev_q.size();
         feed(tbl[i].b);
         check($sformatf("tbl%0d_nev", i), ev_q.size() - n, tbl[i].ev);
         if (tbl[i].ev && ev_q.size() > n) check($sformatf("tbl%0d_evt", i), ev_q[$], tbl[i].evt);
         check($sformatf("tbl%0d_nf_nev", i), nf_ev_q.size() - nn, tbl[i].nf_ev);
         if (tbl[i].nf_ev && nf_ev_q.size() > nn) check($sformatf("tbl%0d_nf_evt", i), nf_ev_q[$], tbl[i].evt);
         check($sformatf("tbl%0d_key", i), {key_down, held_code}, {tbl[i].kd, tbl[i].held});
         check($sformatf("tbl%0d_cnt", i), press_cnt, tbl[i].cnt);
         check($sformatf("tbl%0d_nf_cnt", i), nf_press_cnt, tbl[i].cnt);
      end

      // Back-pressure: three bytes queued, consumer stalled
      evt_ready = 1'b0;
      n = strobe_cnt;
      fifo.push_back(8'h21);
      fifo.push_back(8'h22);
      fifo.push_back(8'h24);
      repeat (8) @(posedge clk);
      #1;
      check("bp_valid", evt_valid, 1'b1);
      check("bp_code", evt_code, 8'h21);
      check("bp_strobes", strobe_cnt - n, 1);
      check("bp_cnt", press_cnt, 8'd6);
      repeat (3) @(posedge clk);
      #1;
      check("bp_code_stable", {evt_ext, evt_brk, evt_rpt, evt_code}, {3'b000, 8'h21});
      check("bp_strobes_stable", strobe_cnt - n, 1);
      n = ev_q.size();
      evt_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_pop_on_ready", nd_n, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      check("bp_drain_n", ev_q.size() - n, 3);
      if (ev_q.size() - n == 3) begin
         check("bp_drain0", ev_q[n],   {3'b000, 8'h21});
         check("bp_drain1", ev_q[n+1], {3'b000, 8'h22});
         check("bp_drain2", ev_q[n+2], {3'b000, 8'h24});
      end
      check("bp_cnt_end", press_cnt, 8'd8);
      check("bp_held", held_code, 9'h024);

      // Overflow after F0 drops the break prefix
      feed(8'hF0);
      kb_overflow = 1'b1;
      @(posedge clk);
      #1;
      kb_overflow = 1'b0;
      check("ovf_err", err, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("ovf_sticky", err, 1'b1);
      n = ev_q.size();
      feed(8'h23);
      check("ovf_nev", ev_q.size() - n, 1);
      if (ev_q.size() > n) check("ovf_evt", ev_q[$], {3'b000, 8'h23});
      check("ovf_cnt", press_cnt, 8'd9);
      clr_err = 1'b1;
      kb_overflow = 1'b1;
      @(posedge clk);
      #1;
      check("ovf_set_wins", err, 1'b1);
      kb_overflow = 1'b0;
      @(posedge clk);
      #1;
      clr_err = 1'b0;
      check("clr_err", err, 1'b0);
      kb_overflow = 1'b1;
      @(posedge clk);
      #1;
      kb_overflow = 1'b0;

      // Asynchronous reset in the middle of a pop
      fifo.push_back(8'h44);
      @(posedge clk);
      #1;
      check("mid_strobe", nd_n, 1'b0);
      #1;
      resetn = 1'b0;
      #1;
      check("arst_strobe", nd_n, 1'b1);
      check("arst_valid", evt_valid, 1'b0);
      check("arst_evt", {evt_ext, evt_brk, evt_rpt, evt_code}, 11'h000);
      check("arst_key", {key_down, held_code}, 10'h000);
      check("arst_cnt", press_cnt, 8'd0);
      check("arst_err", err, 1'b0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("post_rst_cnt", press_cnt, 8'd1);
      check("post_rst_key", {key_down, held_code}, {1'b1, 9'h044});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
